// File: rtl/chess_board_renderer.sv
// Renders the 64-square layout bus as an RGB565 raster of 8x8 squares, one pixel per
// valid/ready handshake, from a snapshot taken at the start of every frame.
//
// state | meaning
// IDLE  | waiting for a layout change or a redraw request
// LATCH | snapshot the layout bus, clear the scan counters
// DRAW  | present pixels; advance on pixelReady
// DONE  | frameDone pulse, then re-latch if another frame is pending
module chess_board_renderer #(
  parameter int          CHESS_SQUARES = 64,
  parameter int          SQUARE_WIDTH  = 8,
  parameter int          MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH,
  parameter int          SQUARE_PIXELS = 30,
  parameter int          BORDER        = 2,
  parameter int          PIECE_MARGIN  = 8,
  parameter int          Y_OFFSET      = 40,
  parameter logic [15:0] LIGHT_COLOUR  = 16'hEF5D,
  parameter logic [15:0] DARK_COLOUR   = 16'h8A22,
  parameter logic [15:0] SELECT_COLOUR = 16'hF800,
  parameter logic [15:0] WHITE_PIECE   = 16'hFFFF,
  parameter logic [15:0] BLACK_PIECE   = 16'h0000
) (
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Layout,
  input  logic                    redraw,
  input  logic                    pixelReady,
  output logic                    pixelWrite,
  output logic [15:0]             pixelData,
  output logic [7:0]              pixelX,
  output logic [8:0]              pixelY,
  output logic                    frameDone,
  output logic                    busy
);

  localparam int PW = $clog2(SQUARE_PIXELS);
  localparam logic [PW-1:0] P_LAST = PW'(SQUARE_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic [MATRIX_WIDTH-1:0] snap_q, snap_d;
  logic [PW-1:0]           px_q, px_d, py_q, py_d;
  logic [2:0]              col_q, col_d, srow_q, srow_d;
  logic [7:0]              x_q, x_d;
  logic [8:0]              y_q, y_d;

  logic       set_req;
  logic       last_pix;
  logic [2:0] brow;
  logic [8:0] sq_base;
  logic [7:0] square;
  logic       on_border, in_token, dark;
  logic [15:0] colour;

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b1;
      snap_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      col_q     <= '0;
      srow_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      px_q      <= px_d;
      py_q      <= py_d;
      col_q     <= col_d;
      srow_q    <= srow_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // During LATCH the snapshot is being refreshed, so a mismatch there is not a new change.
  assign set_req  = redraw || ((state_q != S_LATCH) && (Layout != snap_q));
  assign last_pix = (px_q == P_LAST) && (col_q == 3'd7) && (py_q == P_LAST) && (srow_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | set_req;
    snap_d    = snap_q;
    px_d      = px_q;
    py_d      = py_q;
    col_d     = col_q;
    srow_d    = srow_q;
    x_d       = x_q;
    y_d       = y_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d   = S_LATCH;
          pending_d = redraw;
        end
      end
      S_LATCH: begin
        snap_d  = Layout;
        px_d    = '0;
        py_d    = '0;
        col_d   = '0;
        srow_d  = '0;
        x_d     = '0;
        y_d     = 9'(Y_OFFSET);
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (pixelReady) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else if (px_q != P_LAST) begin
            px_d = px_q + 1'b1;
            x_d  = x_q + 8'd1;
          end else if (col_q != 3'd7) begin
            px_d  = '0;
            col_d = col_q + 3'd1;
            x_d   = x_q + 8'd1;
          end else begin
            px_d  = '0;
            col_d = '0;
            x_d   = '0;
            y_d   = y_q + 9'd1;
            if (py_q != P_LAST) begin
              py_d = py_q + 1'b1;
            end else begin
              py_d   = '0;
              srow_d = srow_q + 3'd1;
            end
          end
        end
      end
      S_DONE: begin
        if (pending_q) begin
          state_d   = S_LATCH;
          pending_d = redraw;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Screen row 0 is the top rank, i.e. board row 7.
  assign brow    = ~srow_q;
  assign sq_base = {brow, col_q, 3'b000};
  assign square  = snap_q[sq_base +: 8];

  always_comb begin
    on_border = (square[7:4] == 4'd1) &&
                ((px_q < PW'(BORDER)) || (px_q >= PW'(SQUARE_PIXELS - BORDER)) ||
                 (py_q < PW'(BORDER)) || (py_q >= PW'(SQUARE_PIXELS - BORDER)));
    in_token  = (square[2:0] != 3'd0) &&
                (px_q >= PW'(PIECE_MARGIN)) && (px_q < PW'(SQUARE_PIXELS - PIECE_MARGIN)) &&
                (py_q >= PW'(PIECE_MARGIN)) && (py_q < PW'(SQUARE_PIXELS - PIECE_MARGIN));
    dark      = ~(brow[0] ^ col_q[0]);
    if (on_border)      colour = SELECT_COLOUR;
    else if (in_token)  colour = square[3] ? BLACK_PIECE : WHITE_PIECE;
    else if (dark)      colour = DARK_COLOUR;
    else                colour = LIGHT_COLOUR;
  end

  assign pixelWrite = (state_q == S_DRAW);
  assign pixelData  = pixelWrite ? colour : 16'h0000;
  assign pixelX     = pixelWrite ? x_q : 8'd0;
  assign pixelY     = pixelWrite ? y_q : 9'd0;
  assign frameDone  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

endmodule
